wb_arbiter2: RTL and testbench

Two-master, one-slave pipelined Wishbone arbiter sitting directly downstream of the core-to-Wishbone converters. It merges the Ibex instruction-fetch and data-access Wishbone masters onto one slave bus, holds ownership for a whole bus cycle, and routes responses back to the owner. It also limits outstanding transfers and optionally aborts hung cycles with an error.

---
 rtl/wb_arbiter2_pkg.sv | 5 +
 rtl/wb_arbiter2_wdog.sv | 20 ++
 rtl/wb_arbiter2.sv | 99 +++++++++
 tb/tb_wb_arbiter2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg: shared state encoding and watchdog timer width for wb_arbiter2
package wb_arbiter2_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
  localparam int TIMER_W = 16;
endpackage

// File: rtl/wb_arbiter2_wdog.sv
// wb_arbiter2_wdog: response watchdog, pulses expire_o after TIMEOUT idle cycles with transfers pending
module wb_arbiter2_wdog
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic expire_o
);
  logic [TIMER_W-1:0] timer_q, timer_d;
  // timer_q counts idle cycles already elapsed, so the current one is the TIMEOUT-th at TIMEOUT-1
  assign expire_o = ~clr_i & (timer_q == TIMER_W'(TIMEOUT - 1));
  assign timer_d = (clr_i | expire_o) ? '0 : timer_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else timer_q <= timer_d;
  end
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master pipelined Wishbone arbiter with outstanding-transfer limit.
// Define WB_ARBITER2_TIMEOUT_EN to add a watchdog that aborts hung cycles with err.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_o,
  input  logic [DW/8-1:0] m0_sel,
  output logic          m0_stall,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_o,
  input  logic [DW/8-1:0] m1_sel,
  output logic          m1_stall,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m_dat_i,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  output logic [DW/8-1:0] s_sel,
  input  logic          s_stall,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic [DW-1:0] s_dat_i
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [OW-1:0] outst_q, outst_d;
  logic own0, own1, full, expire, acc, rsp, rel;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign full = outst_q == OW'(MAX_OUTST);
  assign s_cyc = ((own0 & m0_cyc) | (own1 & m1_cyc)) & ~expire;
  assign s_stb = ((own0 & m0_stb) | (own1 & m1_stb)) & ~full & ~expire;
  assign s_we = (own0 & m0_we) | (own1 & m1_we);
  assign s_adr = own0 ? m0_adr : own1 ? m1_adr : '0;
  assign s_dat_o = own0 ? m0_dat_o : own1 ? m1_dat_o : '0;
  assign s_sel = own0 ? m0_sel : own1 ? m1_sel : '0;
  assign m_dat_i = s_dat_i;
  assign m0_stall = ~own0 | s_stall | full;
  assign m1_stall = ~own1 | s_stall | full;
  assign m0_ack = own0 & s_ack;
  assign m1_ack = own1 & s_ack;
  assign m0_err = own0 & (s_err | expire);
  assign m1_err = own1 & (s_err | expire);
  assign acc = s_stb & ~s_stall;
  assign rsp = s_ack | s_err;
  assign rel = (own0 & ~m0_cyc) | (own1 & ~m1_cyc);
  // Releasing the bus aborts anything in flight, so the count restarts from zero
  assign outst_d = (rel | expire) ? '0 : outst_q + OW'(acc) - OW'(rsp & (outst_q != '0));
`ifdef WB_ARBITER2_TIMEOUT_EN
  wb_arbiter2_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc | rsp | (outst_q == '0)),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0 & |TIMEOUT;
`endif
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) state_d = (m0_cyc & (~m1_cyc | last_q)) ? OWN0 : m1_cyc ? OWN1 : IDLE;
    else if (rel) begin
      state_d = IDLE;
      last_d = own1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      outst_q <= outst_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed vector table plus multi-cycle sequences for wb_arbiter2
module tb_wb_arbiter2;
  import wb_arbiter2_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_dat_o, m1_dat_o, m_dat_i, s_adr, s_dat_o, s_dat_i;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic s_cyc, s_stb, s_we, s_stall, s_ack, s_err;
  int errors = 0, checks = 0;
`ifdef WB_ARBITER2_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  wb_arbiter2 #(.AW(32), .DW(32), .MAX_OUTST(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_o(m0_dat_o),
    .m0_sel(m0_sel), .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_o(m1_dat_o),
    .m1_sel(m1_sel), .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_dat_i(m_dat_i), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_sel(s_sel), .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err),
    .s_dat_i(s_dat_i)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  in;
    logic [7:0]  exp;
    logic [31:0] adr;
    logic [2:0]  oq;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_stall, s_ack, s_err} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [7:0] obs;
  logic [1:0] seq_in[8], seq_exp[8];
  int q[$];
  int sent, acks, om, first, errs;
  logic saw5, acc, sc_at;

  initial begin
    m0_adr = 32'h100; m1_adr = 32'h200;
    m0_dat_o = 32'h0; m1_dat_o = 32'h0;
    m0_sel = 4'hf; m1_sel = 4'h3;
    s_dat_i = 32'hDEADBEEF;
    // in = {m0_cyc,m0_stb,m1_cyc,m1_stb,s_stall,s_ack,s_err}
    // exp = {s_cyc,s_stb,m0_stall,m0_ack,m0_err,m1_stall,m1_ack,m1_err}
    vt[0]  = '{7'b0000000, 8'b00100100, 32'h0,   3'd0};
    vt[1]  = '{7'b1100000, 8'b00100100, 32'h0,   3'd0};
    vt[2]  = '{7'b1100000, 8'b11000100, 32'h100, 3'd0};
    vt[3]  = '{7'b1000010, 8'b10010100, 32'h100, 3'd1};
    vt[4]  = '{7'b0011000, 8'b00000100, 32'h100, 3'd0};
    vt[5]  = '{7'b0011000, 8'b00100100, 32'h0,   3'd0};
    vt[6]  = '{7'b1111100, 8'b11100100, 32'h200, 3'd0};
    vt[7]  = '{7'b1111000, 8'b11100000, 32'h200, 3'd0};
    vt[8]  = '{7'b1110001, 8'b10100001, 32'h200, 3'd1};
    vt[9]  = '{7'b1100000, 8'b00100000, 32'h200, 3'd0};
    vt[10] = '{7'b1111000, 8'b00100100, 32'h0,   3'd0};
    vt[11] = '{7'b1111000, 8'b11000100, 32'h100, 3'd0};
    vt[12] = '{7'b0011000, 8'b00000100, 32'h100, 3'd1};
    vt[13] = '{7'b0011010, 8'b00100100, 32'h0,   3'd0};
    vt[14] = '{7'b0011000, 8'b11100000, 32'h200, 3'd0};
    vt[15] = '{7'b0000010, 8'b00100010, 32'h200, 3'd1};
    vt[16] = '{7'b0000000, 8'b00100100, 32'h0,   3'd0};
    seq_in  = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    seq_exp = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01};

    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_stall, s_ack, s_err} = '0;
    #2;
    chk("reset_outputs", {s_cyc, s_stb, m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err}, 8'b00100100);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack, s_err} = vt[i].in;
      #1;
      obs = {s_cyc, s_stb, m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err};
      chk($sformatf("vec%0d_ctl", i), obs, vt[i].exp);
      chk($sformatf("vec%0d_adr", i), s_adr, vt[i].adr);
      chk($sformatf("vec%0d_outst", i), dut.outst_q, vt[i].oq);
      if (i == 3) chk("read_data", m_dat_i, 32'hDEADBEEF);
      tick();
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      {m0_cyc, m1_cyc} = seq_in[i];
      #1;
      chk($sformatf("alt%0d_stalls", i), {m0_stall, m1_stall}, seq_exp[i]);
      tick();
    end

    do_reset();
    m1_cyc = 1'b1; m1_we = 1'b1;
    tick();
    sent = 0; acks = 0; om = 0; saw5 = 1'b0;
    for (int c = 0; c < 40 && !(sent == 6 && q.size() == 0); c++) begin
      m1_stb = sent < 6;
      m1_dat_o = 32'h1000 + sent;
      s_ack = q.size() > 0 && q[0] + 4 == c;
      #1;
      chk("pipe_stall", m1_stall, om == 4);
      chk("pipe_ack", m1_ack, s_ack);
      if (sent == 4 && m1_stall) saw5 = 1'b1;
      acc = m1_stb && om != 4;
      if (acc) begin
        chk("pipe_wdata", {s_we, s_dat_o}, {1'b1, 32'h1000 + sent});
        q.push_back(c);
        sent++;
      end
      if (s_ack) begin
        void'(q.pop_front());
        acks++;
      end
      om = om + int'(acc) - int'(s_ack && om > 0);
      tick();
    end
    m1_stb = 1'b0; s_ack = 1'b0;
    chk("pipe_5th_stalled", saw5, 1'b1);
    chk("pipe_acks", acks, 6);
    chk("pipe_outst_zero", dut.outst_q, 0);
    m1_cyc = 1'b0; m1_we = 1'b0;
    tick();

    do_reset();
    m0_cyc = 1'b1;
    tick();
    m0_stb = 1'b1;
    tick();
    tick();
    chk("same_pre_outst", dut.outst_q, 2);
    s_ack = 1'b1;
    #1;
    chk("same_accept", {s_stb, m0_stall, m0_ack}, 3'b101);
    tick();
    chk("same_outst", dut.outst_q, 2);
    m0_stb = 1'b0;
    tick();
    tick();
    chk("drain_outst", dut.outst_q, 0);
    s_ack = 1'b0;
    tick();
    chk("drain_floor", dut.outst_q, 0);
    m0_cyc = 1'b0;
    tick();

    do_reset();
    m0_cyc = 1'b1;
    tick();
    m0_stb = 1'b1;
    tick();
    tick();
    chk("abort_pre_outst", dut.outst_q, 2);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("abort_state", dut.state_q, IDLE);
    chk("abort_outst", dut.outst_q, 0);
    tick();
    s_ack = 1'b1;
    #1;
    chk("abort_late_ack", {m0_ack, m1_ack}, 2'b00);
    tick();
    s_ack = 1'b0;
    chk("abort_late_outst", dut.outst_q, 0);

    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {s_cyc, s_stb, m0_stall, m0_ack}, 4'b0010);
    do_reset();

    m0_cyc = 1'b1;
    tick();
    m0_stb = 1'b1;
    #1;
    chk("tmo_accept", m0_stall, 1'b0);
    tick();
    m0_stb = 1'b0;
    first = 0; errs = 0; sc_at = 1'b1;
`ifdef WB_ARBITER2_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (m0_err) begin
        errs++;
        if (first == 0) begin
          first = k;
          sc_at = s_cyc;
        end
      end
      tick();
    end
    chk("tmo_cycle", first, 8);
    chk("tmo_single", errs, 1);
    chk("tmo_scyc_low", sc_at, 1'b0);
`else
    for (int k = 1; k <= 1000; k++) begin
      #1;
      if (m0_err) errs++;
      tick();
    end
    chk("no_tmo_err", errs, 0);
    chk("no_tmo_outst", dut.outst_q, 1);
`endif
    m0_cyc = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
